mac_neuron: RTL and testbench

MAC_NEURON -- requirements
Module: mac_neuron

---
 rtl/mac_neuron.sv | 180 ++++++++++++++++++
 tb/tb_mac_neuron.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_neuron.sv
// Multiply-accumulate neuron: bias plus sequential weighted sum, then a hard-sigmoid activation.
// Define MAC_NEURON_SAT_EN to saturate the shifted sum to WIDTH bits; by default it wraps.
module mac_neuron #(
    parameter int NUM   = 2,
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [NUM*WIDTH-1:0]   i_k,
    input  logic                   i_wr,
    input  logic [NUM*WIDTH-1:0]   i_w,
    input  logic [WIDTH-1:0]       i_b,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_z,
    output logic [WIDTH-1:0]       o_a,
    output logic [NUM*WIDTH-1:0]   o_w,
    output logic [WIDTH-1:0]       o_b,
    output logic                   o_wr_err
);

    localparam int ACC_W = 2*WIDTH + $clog2(NUM+1);
    localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM-1);

    localparam logic signed [ACC_W-1:0] ZMAX = {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ZMIN = {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH:0]   HALF = {{(WIDTH+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
    localparam logic signed [WIDTH:0]   ONE  = {{(WIDTH-FRAC){1'b0}}, 1'b1, {FRAC{1'b0}}};
    localparam logic [WIDTH-1:0]        ONE_Z = {{(WIDTH-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [NUM*WIDTH-1:0]      k_q, k_d;
    logic [NUM*WIDTH-1:0]      opw_q, opw_d;
    logic [NUM*WIDTH-1:0]      w_q, w_d;
    logic [WIDTH-1:0]          b_q, b_d;
    logic [WIDTH-1:0]          z_q, z_d;
    logic [WIDTH-1:0]          a_q, a_d;
    logic                      wr_err_q, wr_err_d;

    logic signed [WIDTH-1:0]   k_arr [NUM];
    logic signed [WIDTH-1:0]   w_arr [NUM];

    // The operation works on a snapshot of the weights taken at accept, so a
    // write landing on the accept edge only affects later vectors.
    for (genvar gi = 0; gi < NUM; gi++) begin : g_unpack
        assign k_arr[gi] = k_q[gi*WIDTH +: WIDTH];
        assign w_arr[gi] = opw_q[gi*WIDTH +: WIDTH];
    end

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   bias_ext;
    logic signed [ACC_W-1:0]   sh;
    logic signed [WIDTH-1:0]   z_sel;
    logic signed [WIDTH:0]     a_pre;
    logic [WIDTH-1:0]          a_sel;

    assign prod     = k_arr[idx_q] * w_arr[idx_q];
    assign prod_ext = {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
    assign bias_ext = {{(ACC_W-WIDTH-FRAC){b_q[WIDTH-1]}}, b_q, {FRAC{1'b0}}};
    assign sh       = acc_q >>> FRAC;

    always_comb begin
`ifdef MAC_NEURON_SAT_EN
        if (sh > ZMAX) begin
            z_sel = {1'b0, {(WIDTH-1){1'b1}}};
        end else if (sh < ZMIN) begin
            z_sel = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            z_sel = sh[WIDTH-1:0];
        end
`else
        z_sel = sh[WIDTH-1:0];
`endif
    end

    // One spare bit keeps z/4 + 0.5 from overflowing before the clamp.
    always_comb begin
        a_pre = ($signed({z_sel[WIDTH-1], z_sel}) >>> 2) + HALF;
        if (a_pre[WIDTH]) begin
            a_sel = '0;
        end else if (a_pre > ONE) begin
            a_sel = ONE_Z;
        end else begin
            a_sel = a_pre[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        k_d      = k_q;
        opw_d    = opw_q;
        w_d      = w_q;
        b_d      = b_q;
        z_d      = z_q;
        a_d      = a_q;
        wr_err_d = 1'b0;
        o_ready  = (state_q == IDLE);
        o_valid  = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (i_wr) begin
                    w_d = i_w;
                    b_d = i_b;
                end
                if (i_valid) begin
                    k_d     = i_k;
                    opw_d   = w_q;
                    acc_d   = bias_ext;
                    idx_d   = '0;
                    state_d = MAC;
                end
            end
            MAC: begin
                acc_d = acc_q + prod_ext;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = ACT;
                end
            end
            ACT: begin
                z_d     = z_sel;
                a_d     = a_sel;
                state_d = DONE;
            end
            DONE: begin
                if (i_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (i_wr && state_q != IDLE) begin
            wr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            acc_q    <= '0;
            k_q      <= '0;
            opw_q    <= '0;
            w_q      <= '0;
            b_q      <= '0;
            z_q      <= '0;
            a_q      <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            k_q      <= k_d;
            opw_q    <= opw_d;
            w_q      <= w_d;
            b_q      <= b_d;
            z_q      <= z_d;
            a_q      <= a_d;
            wr_err_q <= wr_err_d;
        end
    end

    assign o_z      = z_q;
    assign o_a      = a_q;
    assign o_w      = w_q;
    assign o_b      = b_q;
    assign o_wr_err = wr_err_q;

endmodule

// File: tb/tb_mac_neuron.sv
// Randomized scoreboard bench for mac_neuron: stimulus pushes expected results,
// an independent monitor compares them whenever the DUT presents a result.
module tb_mac_neuron;

    localparam int NUM  = 2;
    localparam int W    = 16;
    localparam int FRAC = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               i_valid;
    logic               o_ready;
    logic [NUM*W-1:0]   i_k;
    logic               i_wr;
    logic [NUM*W-1:0]   i_w;
    logic [W-1:0]       i_b;
    logic               o_valid;
    logic               i_ready;
    logic [W-1:0]       o_z;
    logic [W-1:0]       o_a;
    logic [NUM*W-1:0]   o_w;
    logic [W-1:0]       o_b;
    logic               o_wr_err;

    mac_neuron #(.NUM(NUM), .WIDTH(W), .FRAC(FRAC)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_k(i_k),
        .i_wr(i_wr), .i_w(i_w), .i_b(i_b), .o_valid(o_valid), .i_ready(i_ready),
        .o_z(o_z), .o_a(o_a), .o_w(o_w), .o_b(o_b), .o_wr_err(o_wr_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] z;
        logic [W-1:0] a;
    } exp_t;

    exp_t         exp_q[$];
    int           checks = 0;
    int           errors = 0;
    int           txn = 0;
    logic [NUM*W-1:0] w_m;
    logic [W-1:0]     b_m;

    // Reference: real-valued neuron in fixed point using plain integer arithmetic.
    function automatic exp_t model(input logic [NUM*W-1:0] k, input logic [NUM*W-1:0] w,
                                   input logic [W-1:0] b);
        exp_t   r;
        longint sum, shv, zi, ai;
        logic signed [W-1:0] kn, wn, bs;
        bs  = b;
        sum = longint'(bs) * (longint'(1) << FRAC);
        for (int n = 0; n < NUM; n++) begin
            kn = k[n*W +: W];
            wn = w[n*W +: W];
            sum += longint'(kn) * longint'(wn);
        end
        shv = sum >>> FRAC;
`ifdef MAC_NEURON_SAT_EN
        if (shv > (longint'(1) << (W-1)) - 1) zi = (longint'(1) << (W-1)) - 1;
        else if (shv < -(longint'(1) << (W-1))) zi = -(longint'(1) << (W-1));
        else zi = shv;
`else
        zi = shv % (longint'(1) << W);
        if (zi < 0) zi += (longint'(1) << W);
        if (zi >= (longint'(1) << (W-1))) zi -= (longint'(1) << W);
`endif
        ai = (zi >>> 2) + (longint'(1) << (FRAC-1));
        if (ai < 0) ai = 0;
        if (ai > (longint'(1) << FRAC)) ai = longint'(1) << FRAC;
        r.z = W'(zi);
        r.a = W'(ai);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        w_m = '0;
        b_m = '0;
    endtask

    task automatic write_w(input logic [NUM*W-1:0] nw, input logic [W-1:0] nb);
        i_wr = 1'b1;
        i_w  = nw;
        i_b  = nb;
        tick();
        i_wr = 1'b0;
        w_m  = nw;
        b_m  = nb;
        check("idle_write_w", o_w, w_m);
        check("idle_write_b", o_b, b_m);
        check("idle_write_no_err", o_wr_err, 0);
    endtask

    task automatic run_vec(input logic [NUM*W-1:0] k, input int rdy_dly, input bit wr_same,
                           input bit wr_mac, input logic [NUM*W-1:0] nw, input logic [W-1:0] nb);
        int lat;
        lat = 0;
        while (!o_ready && lat < 50) begin
            tick();
            lat++;
        end
        check("ready_before_accept", o_ready, 1);
        i_k     = k;
        i_valid = 1'b1;
        exp_q.push_back(model(k, w_m, b_m));
        if (wr_same) begin
            i_wr = 1'b1;
            i_w  = nw;
            i_b  = nb;
        end
        tick();
        i_valid = 1'b0;
        i_wr    = 1'b0;
        if (wr_same) begin
            w_m = nw;
            b_m = nb;
            check("same_cycle_write_w", o_w, w_m);
        end
        lat = 1;
        if (wr_mac) begin
            i_wr = 1'b1;
            i_w  = ~w_m;
            i_b  = ~b_m;
            tick();
            i_wr = 1'b0;
            lat++;
            check("wr_err_pulse", o_wr_err, 1);
            check("busy_write_w_kept", o_w, w_m);
            check("busy_write_b_kept", o_b, b_m);
            tick();
            lat++;
            check("wr_err_one_cycle", o_wr_err, 0);
        end
        while (!o_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!o_valid) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got no o_valid after %0d cycles, expected %0d", lat, NUM+2);
            do_reset();
            exp_q.delete();
            return;
        end
        check("latency", lat, NUM+2);
        for (int i = 0; i < rdy_dly; i++) begin
            check("ready_low_in_done", o_ready, 0);
            tick();
        end
        check("valid_held", o_valid, 1);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check("valid_drop", o_valid, 0);
        check("ready_back", o_ready, 1);
    endtask

    // Monitor: compare every cycle a result is presented; consume on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && o_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_valid: got o_valid=1 z=%h a=%h, expected no result", o_z, o_a);
                end else begin
                    if (o_z !== exp_q[0].z || o_a !== exp_q[0].a) begin
                        errors++;
                        $display("FAIL result: got z=%h a=%h expected z=%h a=%h",
                                 o_z, o_a, exp_q[0].z, exp_q[0].a);
                    end
                    if (i_ready) begin
                        $display("txn %0d: z=%h a=%h (expected z=%h a=%h)",
                                 txn, o_z, o_a, exp_q[0].z, exp_q[0].a);
                        txn++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic [NUM*W-1:0] rk, rw;
        logic [W-1:0]     rb;
        int               n;
        rst = 1'b1; i_valid = 1'b0; i_k = '0; i_wr = 1'b0; i_w = '0; i_b = '0; i_ready = 1'b0;
        w_m = '0; b_m = '0;
        tick();
        // rst overrides simultaneous write and accept
        i_wr = 1'b1; i_w = '1; i_b = '1; i_valid = 1'b1;
        tick();
        i_wr = 1'b0; i_valid = 1'b0;
        check("rst_ready", o_ready, 1);
        check("rst_valid", o_valid, 0);
        check("rst_z", o_z, 0);
        check("rst_a", o_a, 0);
        check("rst_w", o_w, 0);
        check("rst_b", o_b, 0);
        check("rst_wr_err", o_wr_err, 0);
        rst = 1'b0;
        tick();

        write_w({16'h0080, 16'h0100}, 16'h0000);
        run_vec({16'h0200, 16'h0100}, 0, 1'b0, 1'b0, '0, '0);
        write_w({16'h0100, 16'h0100}, 16'h0000);
        run_vec({16'hFE00, 16'hFE00}, 1, 1'b0, 1'b0, '0, '0);
        run_vec({16'h0000, 16'h0000}, 0, 1'b0, 1'b0, '0, '0);
        write_w({16'h7FFF, 16'h7FFF}, 16'h0000);
        run_vec({16'h7FFF, 16'h7FFF}, 0, 1'b0, 1'b0, '0, '0);
        write_w({16'h0100, 16'h0080}, 16'h0040);
        run_vec({16'h0300, 16'hFF00}, 5, 1'b0, 1'b0, '0, '0);
        run_vec({16'h0180, 16'h0200}, 0, 1'b0, 1'b1, '0, '0);
        run_vec({16'h0100, 16'h0100}, 2, 1'b1, 1'b0, {16'h0200, 16'hFF00}, 16'h0100);
        run_vec({16'h0100, 16'h0100}, 0, 1'b0, 1'b0, '0, '0);

        // Abort in MAC: no result may appear, state and weights cleared.
        i_k = {16'h0100, 16'h0100};
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        check("abort_in_mac_busy", o_ready, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        w_m = '0;
        b_m = '0;
        check("abort_ready", o_ready, 1);
        check("abort_w", o_w, 0);
        check("abort_b", o_b, 0);
        check("abort_valid", o_valid, 0);
        repeat (6) tick();

        for (int it = 0; it < 40; it++) begin
            for (n = 0; n < NUM; n++) begin
                rk[n*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 2047)) - 16'd1024;
                rw[n*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 1023)) - 16'd512;
            end
            rb = ($urandom_range(0, 1) == 0) ? W'($urandom) : W'($urandom_range(0, 511)) - 16'd256;
            if ($urandom_range(0, 2) == 0) write_w(rw, rb);
            run_vec(rk, $urandom_range(0, 3), $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                    ~rw, rb + 16'd1);
        end

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
